// File: rtl/fp_ctrl_sequencer.sv
// Multi-cycle main decoder / sequencer for the RV32F core: decodes opcode/funct5 into a registered
// control bundle and sequences variable-latency FP ops. Optional fused multiply-add decode: RVF_FMA_EN.
module fp_ctrl_sequencer #(
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [6:0] opcode,
  input  logic [4:0] funct5,
  input  logic       flush,
  output logic       ctrl_valid,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       ALUSrc,
  output logic       Branch,
  output logic       MemWrite,
  output logic       Jump,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       fp_RegWrite,
  output logic [4:0] fp_op,
  output logic       illegal,
  output logic       busy,
  output logic [0:0] dbg_state
);

  // Handshake: an instruction is accepted in any cycle where instr_valid and instr_ready are both
  // high; instr_ready depends only on state, flush and rst, never on instr_valid.

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Bundle order: {RegWrite,ImmSrc,ALUSrc,Branch,MemWrite,ResultSrc,ALUOp,Jump,fp_RegWrite}
  localparam logic [12:0] B_LW   = 13'b1_00_1_0_0_01_00_0_0;
  localparam logic [12:0] B_SW   = 13'b0_01_1_0_1_00_00_0_0;
  localparam logic [12:0] B_BR   = 13'b0_10_0_1_0_00_01_0_0;
  localparam logic [12:0] B_R    = 13'b1_00_0_0_0_00_10_0_0;
  localparam logic [12:0] B_I    = 13'b1_00_1_0_0_00_10_0_0;
  localparam logic [12:0] B_JAL  = 13'b1_11_0_0_0_00_00_1_0;
  localparam logic [12:0] B_JALR = 13'b1_00_1_0_0_00_00_1_0;
  localparam logic [12:0] B_FLW  = 13'b0_00_1_0_0_01_00_0_1;
  localparam logic [12:0] B_FPW  = 13'b0_00_0_0_0_00_00_0_1;
  localparam logic [12:0] B_INTW = 13'b1_00_0_0_0_10_00_0_0;

  // Counter is preloaded with L-1 so it reaches 1 on the last busy cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef RVF_FMA_EN
  localparam logic [CNT_W-1:0] FMA_LOAD  = CNT_W'(MUL_LAT);
`endif

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cv_q;
  logic [12:0]      bundle_q;
  logic [4:0]       fp_op_q;
  logic             illegal_q;

  logic [12:0]      dec_bundle;
  logic [4:0]       dec_fp_op;
  logic             dec_illegal;
  logic             dec_multi;
  logic [CNT_W-1:0] dec_load;
  logic             accept;

  always_comb begin
    dec_bundle  = '0;
    dec_fp_op   = '0;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    dec_load    = '0;
    case (opcode)
      7'b0000011:             dec_bundle = B_LW;
      7'b0100011, 7'b0100111: dec_bundle = B_SW;
      7'b1100011:             dec_bundle = B_BR;
      7'b0110011:             dec_bundle = B_R;
      7'b0010011:             dec_bundle = B_I;
      7'b1101111:             dec_bundle = B_JAL;
      7'b1100111:             dec_bundle = B_JALR;
      7'b0000111:             dec_bundle = B_FLW;
      7'b1010011: begin
        dec_fp_op = funct5;
        case (funct5)
          5'b00000, 5'b00001, 5'b00100, 5'b00101, 5'b11010, 5'b11110:
            dec_bundle = B_FPW;
          5'b00010: begin
            dec_bundle = B_FPW;
            dec_multi  = 1'b1;
            dec_load   = MUL_LOAD;
          end
          5'b00011: begin
            dec_bundle = B_FPW;
            dec_multi  = 1'b1;
            dec_load   = DIV_LOAD;
          end
          5'b01011: begin
            dec_bundle = B_FPW;
            dec_multi  = 1'b1;
            dec_load   = SQRT_LOAD;
          end
          5'b11000, 5'b10100, 5'b11100:
            dec_bundle = B_INTW;
          default: begin
            dec_fp_op   = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
`ifdef RVF_FMA_EN
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        dec_bundle = B_FPW;
        dec_fp_op  = {3'b100, opcode[3:2]};
        dec_multi  = 1'b1;
        dec_load   = FMA_LOAD;
      end
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

  assign instr_ready = (state == IDLE) & ~flush & ~rst;
  assign accept      = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cv_q      <= 1'b0;
      bundle_q  <= '0;
      fp_op_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      cv_q <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == WAIT) begin
        if (cnt == CNT_ONE) begin
          state <= IDLE;
          cnt   <= '0;
          cv_q  <= 1'b1;
        end else begin
          cnt <= cnt - CNT_ONE;
        end
      end else if (accept) begin
        bundle_q  <= dec_bundle;
        fp_op_q   <= dec_fp_op;
        illegal_q <= dec_illegal;
        if (dec_multi) begin
          state <= WAIT;
          cnt   <= dec_load;
        end else begin
          cv_q <= 1'b1;
        end
      end
    end
  end

  // The registered pulse is suppressed in a flush or reset cycle so an aborted op never reports.
  assign ctrl_valid = cv_q & ~flush & ~rst;
  assign busy       = (state == WAIT);
  assign dbg_state  = state;
  assign {RegWrite, ImmSrc, ALUSrc, Branch, MemWrite, ResultSrc, ALUOp, Jump, fp_RegWrite} = bundle_q;
  assign fp_op      = fp_op_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_fp_ctrl_sequencer.sv
// Directed testbench for fp_ctrl_sequencer: decode bundles, latency sequencing, flush and reset.
module tb_fp_ctrl_sequencer;

  localparam logic [12:0] E_LW   = 13'b1_00_1_0_0_01_00_0_0;
  localparam logic [12:0] E_BR   = 13'b0_10_0_1_0_00_01_0_0;
  localparam logic [12:0] E_R    = 13'b1_00_0_0_0_00_10_0_0;
  localparam logic [12:0] E_FLW  = 13'b0_00_1_0_0_01_00_0_1;
  localparam logic [12:0] E_FPW  = 13'b0_00_0_0_0_00_00_0_1;
  localparam logic [12:0] E_INTW = 13'b1_00_0_0_0_10_00_0_0;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [6:0] opcode;
  logic [4:0] funct5;
  logic       flush;
  logic       ctrl_valid;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic       ALUSrc;
  logic       Branch;
  logic       MemWrite;
  logic       Jump;
  logic [1:0] ResultSrc;
  logic [1:0] ALUOp;
  logic       fp_RegWrite;
  logic [4:0] fp_op;
  logic       illegal;
  logic       busy;
  logic [0:0] dbg_state;
  logic [12:0] bun;

  int checks = 0;
  int errors = 0;

  assign bun = {RegWrite, ImmSrc, ALUSrc, Branch, MemWrite, ResultSrc, ALUOp, Jump, fp_RegWrite};

  fp_ctrl_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct5(funct5), .flush(flush), .ctrl_valid(ctrl_valid),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .Branch(Branch),
    .MemWrite(MemWrite), .Jump(Jump), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .fp_RegWrite(fp_RegWrite), .fp_op(fp_op), .illegal(illegal), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, checks run 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] f5);
    instr_valid = v;
    opcode      = op;
    funct5      = f5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 7'b0, 5'b0);
    flush = 1'b0;
    step();
    step();
    #2;
    checks++;
    if ({instr_ready, ctrl_valid, busy, illegal} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/cv/busy/ill=%b exp 0000", {instr_ready, ctrl_valid, busy, illegal});
    end
    checks++;
    if ({bun, fp_op, dbg_state} !== 19'b0) begin
      errors++;
      $display("FAIL reset_bundle: got bun=%b fp_op=%b st=%b exp all 0", bun, fp_op, dbg_state);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b exp 1", instr_ready);
    end
    step();
  endtask

  task automatic test_lw();
    drive(1'b1, 7'b0000011, 5'b0);
    #2;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL lw_ready: got %b exp 1", instr_ready);
    end
    step();
    drive(1'b0, 7'b0, 5'b0);
    #2;
    checks++;
    if ({ctrl_valid, busy, illegal, bun} !== {3'b100, E_LW}) begin
      errors++;
      $display("FAIL lw_bundle: got cv/busy/ill=%b bun=%b exp 100 %b", {ctrl_valid, busy, illegal}, bun, E_LW);
    end
    step();
    #2;
    checks++;
    if ({ctrl_valid, bun} !== {1'b0, E_LW}) begin
      errors++;
      $display("FAIL lw_hold: got cv=%b bun=%b exp 0 %b", ctrl_valid, bun, E_LW);
    end
    step();
  endtask

  task automatic test_fdiv();
    drive(1'b1, 7'b1010011, 5'b00011);
    step();
    drive(1'b0, 7'b0, 5'b0);
    for (int k = 1; k < 12; k++) begin
      #2;
      checks++;
      if ({instr_ready, busy, ctrl_valid} !== 3'b010) begin
        errors++;
        $display("FAIL fdiv_wait_%0d: got rdy/busy/cv=%b exp 010", k, {instr_ready, busy, ctrl_valid});
      end
      step();
    end
    #2;
    checks++;
    if ({instr_ready, busy, ctrl_valid} !== 3'b101) begin
      errors++;
      $display("FAIL fdiv_done: got rdy/busy/cv=%b exp 101", {instr_ready, busy, ctrl_valid});
    end
    checks++;
    if ({bun, fp_op} !== {E_FPW, 5'b00011}) begin
      errors++;
      $display("FAIL fdiv_bundle: got bun=%b fp_op=%b exp %b 00011", bun, fp_op, E_FPW);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 7'b0110011, 5'b0);
    #2;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready0: got %b exp 1", instr_ready);
    end
    step();
    drive(1'b1, 7'b0000111, 5'b0);
    #2;
    checks++;
    if ({ctrl_valid, instr_ready, bun} !== {2'b11, E_R}) begin
      errors++;
      $display("FAIL b2b_add: got cv/rdy=%b bun=%b exp 11 %b", {ctrl_valid, instr_ready}, bun, E_R);
    end
    step();
    drive(1'b1, 7'b1100011, 5'b0);
    #2;
    checks++;
    if ({ctrl_valid, instr_ready, bun} !== {2'b11, E_FLW}) begin
      errors++;
      $display("FAIL b2b_flw: got cv/rdy=%b bun=%b exp 11 %b", {ctrl_valid, instr_ready}, bun, E_FLW);
    end
    step();
    drive(1'b0, 7'b0, 5'b0);
    #2;
    checks++;
    if ({ctrl_valid, instr_ready, bun} !== {2'b11, E_BR}) begin
      errors++;
      $display("FAIL b2b_beq: got cv/rdy=%b bun=%b exp 11 %b", {ctrl_valid, instr_ready}, bun, E_BR);
    end
    step();
    #2;
    checks++;
    if (ctrl_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got cv=%b exp 0", ctrl_valid);
    end
    step();
  endtask

  task automatic test_flush();
    int pulses;
    drive(1'b1, 7'b1010011, 5'b01011);
    step();
    drive(1'b0, 7'b0, 5'b0);
    repeat (4) step();
    flush = 1'b1;
    drive(1'b1, 7'b0000011, 5'b0);
    #2;
    checks++;
    if ({instr_ready, ctrl_valid, busy} !== 3'b001) begin
      errors++;
      $display("FAIL flush_cycle: got rdy/cv/busy=%b exp 001", {instr_ready, ctrl_valid, busy});
    end
    step();
    flush = 1'b0;
    #2;
    checks++;
    if ({instr_ready, ctrl_valid, busy, dbg_state} !== 4'b1000) begin
      errors++;
      $display("FAIL flush_after: got rdy/cv/busy/st=%b exp 1000", {instr_ready, ctrl_valid, busy, dbg_state});
    end
    step();
    drive(1'b0, 7'b0, 5'b0);
    #2;
    checks++;
    if ({ctrl_valid, bun} !== {1'b1, E_LW}) begin
      errors++;
      $display("FAIL flush_reaccept: got cv=%b bun=%b exp 1 %b", ctrl_valid, bun, E_LW);
    end
    pulses = 0;
    repeat (14) begin
      step();
      #2;
      if (ctrl_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL flush_no_stale_pulse: got %0d pulses exp 0", pulses);
    end
    // Flush while idle must also block acceptance.
    flush = 1'b1;
    drive(1'b1, 7'b0100011, 5'b0);
    #2;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready: got %b exp 0", instr_ready);
    end
    step();
    flush = 1'b0;
    drive(1'b0, 7'b0, 5'b0);
    #2;
    checks++;
    if ({ctrl_valid, bun} !== {1'b0, E_LW}) begin
      errors++;
      $display("FAIL flush_idle_noaccept: got cv=%b bun=%b exp 0 %b", ctrl_valid, bun, E_LW);
    end
    step();
  endtask

  task automatic test_illegal();
    drive(1'b1, 7'b1111111, 5'b0);
    step();
    drive(1'b1, 7'b1010011, 5'b00110);
    #2;
    checks++;
    if ({ctrl_valid, illegal, bun, fp_op} !== {2'b11, 18'b0}) begin
      errors++;
      $display("FAIL illegal_opcode: got cv/ill=%b bun=%b fp_op=%b exp 11 0 0", {ctrl_valid, illegal}, bun, fp_op);
    end
    step();
    drive(1'b1, 7'b1010011, 5'b11000);
    #2;
    checks++;
    if ({ctrl_valid, illegal, bun, fp_op} !== {2'b11, 18'b0}) begin
      errors++;
      $display("FAIL illegal_funct5: got cv/ill=%b bun=%b fp_op=%b exp 11 0 0", {ctrl_valid, illegal}, bun, fp_op);
    end
    step();
    drive(1'b0, 7'b0, 5'b0);
    #2;
    checks++;
    if ({ctrl_valid, illegal, bun, fp_op} !== {2'b10, E_INTW, 5'b11000}) begin
      errors++;
      $display("FAIL intwrite: got cv/ill=%b bun=%b fp_op=%b exp 10 %b 11000", {ctrl_valid, illegal}, bun, fp_op, E_INTW);
    end
    step();
  endtask

  task automatic test_fmul_reset();
    int pulses;
    drive(1'b1, 7'b1010011, 5'b00010);
    step();
    drive(1'b0, 7'b0, 5'b0);
    #2;
    checks++;
    if ({busy, ctrl_valid} !== 2'b10) begin
      errors++;
      $display("FAIL fmul_t1: got busy/cv=%b exp 10", {busy, ctrl_valid});
    end
    step();
    step();
    #2;
    checks++;
    if ({ctrl_valid, busy, fp_op, bun} !== {2'b10, 5'b00010, E_FPW}) begin
      errors++;
      $display("FAIL fmul_done: got cv/busy=%b fp_op=%b bun=%b exp 10 00010 %b", {ctrl_valid, busy}, fp_op, bun, E_FPW);
    end
    step();
    // Second FMUL aborted by reset one cycle after acceptance.
    drive(1'b1, 7'b1010011, 5'b00010);
    step();
    drive(1'b0, 7'b0, 5'b0);
    rst = 1'b1;
    #2;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got %b exp 0", instr_ready);
    end
    step();
    rst = 1'b0;
    #2;
    checks++;
    if ({ctrl_valid, busy, illegal, bun, fp_op} !== 21'b0) begin
      errors++;
      $display("FAIL rst_abort: got cv/busy/ill=%b bun=%b fp_op=%b exp all 0", {ctrl_valid, busy, illegal}, bun, fp_op);
    end
    pulses = 0;
    repeat (4) begin
      step();
      #2;
      if (ctrl_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_no_pulse: got %0d pulses exp 0", pulses);
    end
    step();
  endtask

  task automatic test_fma();
    drive(1'b1, 7'b1000011, 5'b0);
    step();
    drive(1'b0, 7'b0, 5'b0);
`ifdef RVF_FMA_EN
    for (int k = 1; k < 4; k++) begin
      #2;
      checks++;
      if ({busy, ctrl_valid} !== 2'b10) begin
        errors++;
        $display("FAIL fma_wait_%0d: got busy/cv=%b exp 10", k, {busy, ctrl_valid});
      end
      step();
    end
    #2;
    checks++;
    if ({ctrl_valid, illegal, bun, fp_op} !== {2'b10, E_FPW, 5'b10000}) begin
      errors++;
      $display("FAIL fma_done: got cv/ill=%b bun=%b fp_op=%b exp 10 %b 10000", {ctrl_valid, illegal}, bun, fp_op, E_FPW);
    end
`else
    #2;
    checks++;
    if ({ctrl_valid, illegal, bun, fp_op} !== {2'b11, 18'b0}) begin
      errors++;
      $display("FAIL fma_illegal: got cv/ill=%b bun=%b fp_op=%b exp 11 0 0", {ctrl_valid, illegal}, bun, fp_op);
    end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_fdiv();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_fmul_reset();
    test_fma();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
